// File: rtl/sliding_window.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a shifting window.
// Optional build macro SLIDING_WINDOW_ZERO_INVALID_EN zeroes o_window whenever o_valid is low.
module sliding_window #(
    parameter int unsigned IMG_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_window [0:8]
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = 2;
    localparam int unsigned WIN_N = 9;

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] lb_top [0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] lb_mid [0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] win    [0:WIN_N-1];
    logic [DATA_WIDTH-1:0] shifted_c [0:WIN_N-1];
    logic [DATA_WIDTH-1:0] top_c;
    logic [DATA_WIDTH-1:0] mid_c;
    logic                  complete_c;

    // Window shifted left one column with the new right column {top, mid, i_data}.
    always_comb begin
        top_c      = lb_top[col];
        mid_c      = lb_mid[col];
        complete_c = (row >= ROW_W'(2)) && (col >= COL_W'(2));
        shifted_c[0] = win[1];
        shifted_c[1] = win[2];
        shifted_c[2] = top_c;
        shifted_c[3] = win[4];
        shifted_c[4] = win[5];
        shifted_c[5] = mid_c;
        shifted_c[6] = win[7];
        shifted_c[7] = win[8];
        shifted_c[8] = i_data;
    end

    // Line buffers carry no reset: stale entries are overwritten before any valid window uses them.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            lb_top[col] <= mid_c;
            lb_mid[col] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (i_valid) begin
            if (col == COL_W'(IMG_WIDTH - 1)) begin
                col <= '0;
                if (row != ROW_W'(2)) begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_N; i++) begin
                win[i] <= '0;
            end
        end else if (i_valid) begin
            for (int i = 0; i < WIN_N; i++) begin
                win[i] <= shifted_c[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            for (int i = 0; i < WIN_N; i++) begin
                o_window[i] <= '0;
            end
        end else begin
            o_valid <= i_valid && complete_c;
`ifdef SLIDING_WINDOW_ZERO_INVALID_EN
            for (int i = 0; i < WIN_N; i++) begin
                o_window[i] <= (i_valid && complete_c) ? shifted_c[i] : '0;
            end
`else
            if (i_valid) begin
                for (int i = 0; i < WIN_N; i++) begin
                    o_window[i] <= shifted_c[i];
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_sliding_window.sv
// Scoreboard bench for sliding_window: expected windows are derived from an image model of the pixel stream.
module tb_sliding_window;

    localparam int W = 5;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_valid;
    logic [7:0] o_window [0:8];

    int checks;
    int failures;
    int n;
    int hist [0:255];
    logic [71:0] sb [$];
    logic        exp_v;

    sliding_window #(.IMG_WIDTH(W), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_window (o_window)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] pack_win();
        logic [71:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p = {p[63:0], o_window[i]};
        return p;
    endfunction

    // Drive one cycle; the model places each accepted pixel at (row, col) = (n / W, n % W).
    task automatic step(input logic v, input int d);
        logic [71:0] w;
        int r;
        int c;
        i_valid = v;
        i_data  = 8'(d);
        exp_v   = 1'b0;
        if (v) begin
            hist[n] = d;
            r = n / W;
            c = n % W;
            if (r >= 2 && c >= 2) begin
                w = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w = {w[63:0], 8'(hist[(r - 2 + i) * W + (c - 2 + j)])};
                sb.push_back(w);
                exp_v = 1'b1;
            end
            n++;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", o_valid);
        end
        checks++;
        if (pack_win() !== 72'd0) begin
            failures++;
            $display("FAIL reset_window got=%h want=0", pack_win());
        end
    endtask

    task automatic test_continuous();
        int pulses;
        logic [71:0] w;
        pulses = 0;
        do_reset();
        for (int p = 1; p <= 25; p++) begin
            step(1'b1, p);
            checks++;
            if (o_valid !== exp_v) begin
                failures++;
                $display("FAIL cont_valid pix=%0d got=%b want=%b", p, o_valid, exp_v);
            end
            if (exp_v) begin
                w = sb.pop_front();
                checks++;
                if (pack_win() !== w) begin
                    failures++;
                    $display("FAIL cont_window pix=%0d got=%h want=%h", p, pack_win(), w);
                end
            end
            if (o_valid === 1'b1) pulses++;
            w = '0;
            case (p)
                13: w = {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
                14: w = {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14};
                25: w = {8'd13, 8'd14, 8'd15, 8'd18, 8'd19, 8'd20, 8'd23, 8'd24, 8'd25};
                default: w = '0;
            endcase
            if (w != 72'd0) begin
                checks++;
                if (pack_win() !== w) begin
                    failures++;
                    $display("FAIL cont_known pix=%0d got=%h want=%h", p, pack_win(), w);
                end
            end
        end
        checks++;
        if (pulses != 9) begin
            failures++;
            $display("FAIL cont_pulses got=%0d want=9", pulses);
        end
    endtask

    task automatic test_row_edge();
        logic [71:0] w;
        do_reset();
        for (int p = 1; p <= 18; p++) begin
            step(1'b1, p);
            if (exp_v) w = sb.pop_front();
            if (p == 16 || p == 17) begin
                checks++;
                if (o_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL edge_valid pix=%0d got=%b want=0", p, o_valid);
                end
            end
        end
        w = {8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18};
        checks++;
        if (o_valid !== 1'b1 || pack_win() !== w) begin
            failures++;
            $display("FAIL edge_window got=%b/%h want=1/%h", o_valid, pack_win(), w);
        end
    endtask

    task automatic test_stall();
        int pulses;
        int gap;
        logic [71:0] w;
        logic [71:0] held;
        pulses = 0;
        do_reset();
        for (int p = 1; p <= 25; p++) begin
            gap = ($urandom_range(0, 3) == 0 || p == 13) ? int'($urandom_range(1, 3)) : 0;
            held = pack_win();
`ifdef SLIDING_WINDOW_ZERO_INVALID_EN
            if (p > 1) held = '0;
`endif
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 0);
                checks++;
                if (o_valid !== 1'b0 || pack_win() !== held) begin
                    failures++;
                    $display("FAIL stall_gap pix=%0d got=%b/%h want=0/%h", p, o_valid, pack_win(), held);
                end
            end
            step(1'b1, p);
            checks++;
            if (o_valid !== exp_v) begin
                failures++;
                $display("FAIL stall_valid pix=%0d got=%b want=%b", p, o_valid, exp_v);
            end
            if (exp_v) begin
                w = sb.pop_front();
                checks++;
                if (pack_win() !== w) begin
                    failures++;
                    $display("FAIL stall_window pix=%0d got=%h want=%h", p, pack_win(), w);
                end
            end
            if (o_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 9) begin
            failures++;
            $display("FAIL stall_pulses got=%0d want=9", pulses);
        end
    endtask

    task automatic test_mid_reset();
        logic [71:0] w;
        logic        seen;
        do_reset();
        for (int p = 1; p <= 14; p++) step(1'b1, p);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || pack_win() !== 72'd0) begin
            failures++;
            $display("FAIL midrst_async got=%b/%h want=0/0", o_valid, pack_win());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        sb.delete();
        seen = 1'b0;
        for (int p = 1; p <= 25; p++) begin
            step(1'b1, p);
            checks++;
            if (o_valid !== exp_v) begin
                failures++;
                $display("FAIL midrst_valid pix=%0d got=%b want=%b", p, o_valid, exp_v);
            end
            if (exp_v) w = sb.pop_front();
            if (o_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                w = {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
                checks++;
                if (pack_win() !== w) begin
                    failures++;
                    $display("FAIL midrst_first got=%h want=%h", pack_win(), w);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [71:0] w;
        pulses = 0;
        do_reset();
        for (int p = 1; p <= 50; p++) begin
            step(1'b1, p);
            checks++;
            if (o_valid !== exp_v) begin
                failures++;
                $display("FAIL b2b_valid pix=%0d got=%b want=%b", p, o_valid, exp_v);
            end
            if (exp_v) begin
                w = sb.pop_front();
                checks++;
                if (pack_win() !== w) begin
                    failures++;
                    $display("FAIL b2b_window pix=%0d got=%h want=%h", p, pack_win(), w);
                end
            end
            if (o_valid === 1'b1) pulses++;
            if (p == 28) begin
                w = {8'd16, 8'd17, 8'd18, 8'd21, 8'd22, 8'd23, 8'd26, 8'd27, 8'd28};
                checks++;
                if (o_valid !== 1'b1 || pack_win() !== w) begin
                    failures++;
                    $display("FAIL b2b_known got=%b/%h want=1/%h", o_valid, pack_win(), w);
                end
            end
        end
        checks++;
        if (pulses != 24) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d want=24", pulses);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n        = 0;
        exp_v    = 1'b0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        test_reset();
        test_continuous();
        test_row_edge();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
